// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB-style completer with eight 32-bit registers, wait states and error decode
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 12
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_regs #(
  parameter int          ADDR_WIDTH = `APB_ADDR_WIDTH,
  parameter int          DATA_WIDTH = `APB_DATA_WIDTH,
  parameter logic [31:0] ID_VALUE   = 32'hA5B0_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [2:0]              prot,
  input  logic [3:0]              wait_states,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slv_error,
  output logic                    proto_err
);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_e;

  state_e                  state_q, state_d, cur_state;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    priv_q, priv_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [7];
  logic [DATA_WIDTH-1:0]   regs_d [7];
  logic [2:0]              idx;
  logic                    access_err;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    unused_prot;

  assign unused_prot = ^prot[2:1];

  // The setup-phase cycle itself is the SETUP state, so a zero-wait access completes on the first enable cycle.
  assign cur_state = (state_q == IDLE && sel && !enable) ? SETUP : state_q;

  assign idx        = addr_q[4:2];
  assign access_err = (addr_q[1:0] != 2'b00)
                   || (addr_q >= ADDR_WIDTH'(32))
                   || (write_q && idx == 3'd7)
                   || (idx >= 3'd4 && idx <= 3'd6 && !priv_q);

  always_comb begin
    rd_val = DATA_WIDTH'(ID_VALUE);
    for (int i = 0; i < 7; i++) begin
      if (idx == 3'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d   = cur_state;
    addr_d    = addr_q;
    write_d   = write_q;
    priv_d    = priv_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    ready     = 1'b0;
    slv_error = 1'b0;
    rdata     = '0;
    proto_err = 1'b0;
    case (cur_state)
      IDLE: begin
        state_d = IDLE;
        if (enable) proto_err = 1'b1;
      end
      SETUP: begin
        addr_d  = addr;
        write_d = write;
        priv_d  = prot[0];
        wdata_d = wdata;
        strb_d  = strb;
        cnt_d   = wait_states;
        state_d = (wait_states == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (!sel) begin
          proto_err = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP: begin
        ready     = 1'b1;
        slv_error = access_err;
        if (!access_err) begin
          if (!write_q) begin
            rdata = rd_val;
          end else begin
            for (int i = 0; i < 7; i++) begin
              for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (idx == 3'(i) && strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
              end
            end
          end
        end
        state_d = (sel && !enable) ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      ready     = 1'b0;
      slv_error = 1'b0;
      rdata     = '0;
      proto_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      priv_q  <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 7; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      priv_q  <= priv_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 7; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb/tb_apb_slave_regs.sv - directed self-checking bench for apb_slave_regs
module tb_apb_slave_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        sel, enable, write;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [3:0]  wait_states;
  logic [31:0] rdata;
  logic        ready, slv_error, proto_err;

  int checks   = 0;
  int failures = 0;

  apb_slave_regs dut (
    .clk(clk), .rst(rst), .addr(addr), .sel(sel), .enable(enable), .write(write),
    .wdata(wdata), .strb(strb), .prot(prot), .wait_states(wait_states),
    .rdata(rdata), .ready(ready), .slv_error(slv_error), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer; the access phase scrambles addr/wdata/write to confirm the setup values are latched.
  task automatic xfer(input string tag, input logic [11:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input logic [3:0] ws,
                      output logic [31:0] rd, output logic er);
    int n;
    @(posedge clk); #1;
    sel = 1'b1; enable = 1'b0; addr = a; write = w; wdata = wd; strb = st; prot = pr; wait_states = ws;
    @(posedge clk); #1;
    enable = 1'b1; addr = ~a; wdata = ~wd; write = ~w; wait_states = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 20);
    check({tag, " ready_cycle"}, n, ws + 1);
    rd = rdata;
    er = slv_error;
  endtask

  task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                          input logic [2:0] pr, input logic [3:0] ws, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xfer(tag, a, 1'b1, wd, st, pr, ws, rd, er);
    check({tag, " slv_error"}, er, exp_err);
  endtask

  task automatic do_read(input string tag, input logic [11:0] a, input logic [2:0] pr, input logic [3:0] ws,
                         input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xfer(tag, a, 1'b0, 32'h0, 4'h0, pr, ws, rd, er);
    check({tag, " slv_error"}, er, exp_err);
    check({tag, " rdata"}, rd, exp_data);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
  endtask

  initial begin
    logic rdy_seen;
    rst = 1'b1; sel = 1'b1; enable = 1'b1; addr = '0; write = 1'b1; wdata = '1;
    strb = 4'hF; prot = 3'b001; wait_states = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", ready, 0);
    check("reset slv_error", slv_error, 0);
    check("reset proto_err", proto_err, 0);
    check("reset rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("idle proto_err", proto_err, 0);

    do_read("rd reg0 after reset", 12'h000, 3'b001, 4'd0, 32'h0, 1'b0);

    do_write("wr 0x04 zero-wait", 12'h004, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, 1'b0);
    do_read("rd 0x04", 12'h004, 3'b000, 4'd1, 32'hDEADBEEF, 1'b0);

    do_write("wr 0x00 partial ws3", 12'h000, 32'h11223344, 4'b0101, 3'b000, 4'd3, 1'b0);
    do_read("rd 0x00 partial", 12'h000, 3'b000, 4'd0, 32'h00220044, 1'b0);

    do_read("rd 0x20 out of range", 12'h020, 3'b001, 4'd1, 32'h0, 1'b1);
    do_read("rd 0x02 misaligned", 12'h002, 3'b001, 4'd0, 32'h0, 1'b1);
    do_write("wr 0x1C read-only", 12'h01C, 32'h0BADF00D, 4'hF, 3'b001, 4'd2, 1'b1);
    do_read("rd 0x1C id", 12'h01C, 3'b000, 4'd0, 32'hA5B00001, 1'b0);
    do_write("wr 0x10 unpriv", 12'h010, 32'h12345678, 4'hF, 3'b000, 4'd0, 1'b1);
    do_read("rd 0x10 unchanged", 12'h010, 3'b001, 4'd0, 32'h0, 1'b0);

    do_write("wr 0x10 priv", 12'h010, 32'hCAFE0000, 4'hF, 3'b001, 4'd1, 1'b0);
    do_read("rd 0x10 priv", 12'h010, 3'b001, 4'd0, 32'hCAFE0000, 1'b0);
    do_read("rd 0x10 unpriv", 12'h010, 3'b000, 4'd0, 32'h0, 1'b1);

    do_write("wr 0x04 strb zero", 12'h004, 32'hFFFFFFFF, 4'h0, 3'b000, 4'd0, 1'b0);
    do_read("rd 0x04 after strb zero", 12'h004, 3'b000, 4'd0, 32'hDEADBEEF, 1'b0);

    go_idle();
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check("enable w/o setup proto_err", proto_err, 1);
    check("enable w/o setup ready", ready, 0);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check("enable w/o setup pulse ends", proto_err, 0);
    check("enable w/o setup still no ready", ready, 0);

    @(posedge clk); #1;
    sel = 1'b1; enable = 1'b0; addr = 12'h008; write = 1'b1; wdata = 32'h55AA55AA; strb = 4'hF; wait_states = 4'd3;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("abort in wait proto_err", proto_err, 1);
    check("abort in wait ready", ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort pulse ends", proto_err, 0);
    do_read("rd 0x08 after abort", 12'h008, 3'b000, 4'd0, 32'h0, 1'b0);

    go_idle();
    @(posedge clk); #1;
    sel = 1'b1; enable = 1'b0; addr = 12'h000; write = 1'b1; wdata = 32'hFFFFFFFF; strb = 4'hF;
    prot = 3'b001; wait_states = 4'd4;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    rdy_seen = ready;
    check("rst mid proto_err", proto_err, 0);
    check("rst mid rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0; enable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready === 1'b1) rdy_seen = 1'b1;
    end
    check("rst mid no ready", rdy_seen, 0);
    for (int i = 0; i < 7; i++) begin
      do_read($sformatf("rd reg%0d after mid reset", i), 12'(4 * i), 3'b001, 4'd0, 32'h0, 1'b0);
    end
    do_read("rd 0x1C after mid reset", 12'h01C, 3'b001, 4'd2, 32'hA5B00001, 1'b0);

    go_idle();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
